// File: rtl/nf10_input_arbiter_rr.sv
// Packet-granular round-robin merge of five AXI4-Stream inputs into one output slice.
// Define NF10_INPUT_ARBITER_SRC_STAMP_EN to stamp tuser[23:16] on each packet's first beat.
module nf10_input_arbiter_rr #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_INPUTS         = 5
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_0,
    input  logic                                 s_axis_tvalid_0,
    output logic                                 s_axis_tready_0,
    input  logic                                 s_axis_tlast_0,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_1,
    input  logic                                 s_axis_tvalid_1,
    output logic                                 s_axis_tready_1,
    input  logic                                 s_axis_tlast_1,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_2,
    input  logic                                 s_axis_tvalid_2,
    output logic                                 s_axis_tready_2,
    input  logic                                 s_axis_tlast_2,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_3,
    input  logic                                 s_axis_tvalid_3,
    output logic                                 s_axis_tready_3,
    input  logic                                 s_axis_tlast_3,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_4,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_4,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_4,
    input  logic                                 s_axis_tvalid_4,
    output logic                                 s_axis_tready_4,
    input  logic                                 s_axis_tlast_4,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast
);

    localparam int N  = C_NUM_INPUTS;
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] in_data [N];
    logic [SW-1:0] in_strb [N];
    logic [UW-1:0] in_user [N];
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_last;
    logic [N-1:0]  in_ready;

    assign in_data[0] = s_axis_tdata_0;
    assign in_data[1] = s_axis_tdata_1;
    assign in_data[2] = s_axis_tdata_2;
    assign in_data[3] = s_axis_tdata_3;
    assign in_data[4] = s_axis_tdata_4;
    assign in_strb[0] = s_axis_tstrb_0;
    assign in_strb[1] = s_axis_tstrb_1;
    assign in_strb[2] = s_axis_tstrb_2;
    assign in_strb[3] = s_axis_tstrb_3;
    assign in_strb[4] = s_axis_tstrb_4;
    assign in_user[0] = s_axis_tuser_0;
    assign in_user[1] = s_axis_tuser_1;
    assign in_user[2] = s_axis_tuser_2;
    assign in_user[3] = s_axis_tuser_3;
    assign in_user[4] = s_axis_tuser_4;

    assign in_valid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                       s_axis_tvalid_1, s_axis_tvalid_0};
    assign in_last  = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2,
                       s_axis_tlast_1, s_axis_tlast_0};

    assign s_axis_tready_0 = in_ready[0];
    assign s_axis_tready_1 = in_ready[1];
    assign s_axis_tready_2 = in_ready[2];
    assign s_axis_tready_3 = in_ready[3];
    assign s_axis_tready_4 = in_ready[4];

    logic [2:0] grant;
    logic [2:0] rr_ptr;
    logic [2:0] pick;
    logic       found;

    // First valid input at or after rr_ptr, wrapping modulo N.
    always_comb begin
        logic [3:0] idx;
        idx   = '0;
        found = 1'b0;
        pick  = rr_ptr;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'(N))
                idx = idx - 4'(N);
            if (!found && in_valid[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    logic          can_take;
    logic          cur_valid;
    logic          cur_last;
    logic          load;
    logic [UW-1:0] cur_user;

    assign can_take  = !m_axis_tvalid || m_axis_tready;
    assign cur_valid = in_valid[grant];
    assign cur_last  = in_last[grant];
    assign load      = (state == PKT) && cur_valid && can_take;

    always_comb begin
        in_ready = '0;
        if (state == PKT && can_take)
            in_ready = 5'b00001 << grant;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (found) state_nxt = PKT;
            PKT:  if (load && cur_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found)
                grant <= pick;
            if (load && cur_last)
                rr_ptr <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
        end
    end

`ifdef NF10_INPUT_ARBITER_SRC_STAMP_EN
    logic       first_beat;
    logic [7:0] stamp;

    // DMA port gets its own code; MAC ports use one-hot even bit positions.
    assign stamp = (grant == 3'd4) ? 8'h02
                                   : 8'h01 << {grant[1:0], 1'b0};

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset)
            first_beat <= 1'b0;
        else if (state == IDLE && found)
            first_beat <= 1'b1;
        else if (load)
            first_beat <= 1'b0;
    end

    always_comb begin
        cur_user = in_user[grant];
        if (first_beat)
            cur_user[23:16] = stamp;
    end
`else
    assign cur_user = in_user[grant];
`endif

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= in_data[grant];
            m_axis_tstrb  <= in_strb[grant];
            m_axis_tuser  <= cur_user;
            m_axis_tlast  <= cur_last;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nf10_input_arbiter_rr.sv
// Directed bench for nf10_input_arbiter_rr: reset, rotation order,
// pointer wrap, backpressure, mid-packet gaps and source stamping.
`timescale 1ns/1ps
module tb_nf10_input_arbiter_rr;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata [5];
    logic [SW-1:0] s_tstrb [5];
    logic [UW-1:0] s_tuser [5];
    logic [4:0]    s_tvalid;
    logic [4:0]    s_tlast;
    logic [4:0]    s_tready;

    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    nf10_input_arbiter_rr dut (
        .axi_aclk(clk), .axi_reset(rst),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]),
        .s_axis_tuser_0(s_tuser[0]), .s_axis_tvalid_0(s_tvalid[0]),
        .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]),
        .s_axis_tuser_1(s_tuser[1]), .s_axis_tvalid_1(s_tvalid[1]),
        .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]),
        .s_axis_tuser_2(s_tuser[2]), .s_axis_tvalid_2(s_tvalid[2]),
        .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
        .s_axis_tdata_3(s_tdata[3]), .s_axis_tstrb_3(s_tstrb[3]),
        .s_axis_tuser_3(s_tuser[3]), .s_axis_tvalid_3(s_tvalid[3]),
        .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3(s_tlast[3]),
        .s_axis_tdata_4(s_tdata[4]), .s_axis_tstrb_4(s_tstrb[4]),
        .s_axis_tuser_4(s_tuser[4]), .s_axis_tvalid_4(s_tvalid[4]),
        .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4(s_tlast[4]),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Source models: packets left, length, beat index, packet number, gap.
    int         pk_left [5];
    int         plen    [5];
    int         beat    [5];
    int         pkn     [5];
    int         gap_at  [5];
    int         gap_len [5];
    logic [7:0] usrc    [5];

    logic [4:0] xfer;
    logic [4:0] xlast;
    logic [4:0] rdy;

    logic [31:0] log_data [$];
    logic [31:0] log_strb [$];
    logic [7:0]  log_src  [$];
    logic [15:0] log_len  [$];
    logic        log_last [$];
    int          log_cyc  [$];

    logic        cur_v, cur_r, cur_l, prv_v, prv_r, prv_l;
    logic [31:0] cur_d, prv_d;
    logic [UW-1:0] cur_u, prv_u;

    task automatic drive_inputs();
        for (int i = 0; i < 5; i++) begin
            s_tdata[i] = '0;
            s_tdata[i][7:0]   = 8'(beat[i]);
            s_tdata[i][15:8]  = 8'(pkn[i]);
            s_tdata[i][23:16] = 8'(i);
            s_tdata[i][DW-1:DW-8] = 8'hA0 | 8'(i);
            s_tuser[i] = '0;
            s_tuser[i][15:0]  = 16'(plen[i]);
            s_tuser[i][23:16] = usrc[i];
            s_tuser[i][UW-1]  = 1'b1;
            s_tlast[i]  = (beat[i] == plen[i] - 1);
            s_tstrb[i]  = s_tlast[i] ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            s_tvalid[i] = (pk_left[i] > 0) &&
                          !(beat[i] == gap_at[i] && gap_len[i] > 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        rdy   = s_tready;
        xfer  = s_tvalid & s_tready;
        xlast = s_tvalid & s_tready & s_tlast;
        prv_v = cur_v; prv_r = cur_r; prv_l = cur_l;
        prv_d = cur_d; prv_u = cur_u;
        cur_v = m_tvalid; cur_r = m_tready; cur_l = m_tlast;
        cur_d = m_tdata[31:0]; cur_u = m_tuser;
        if (m_tvalid && m_tready) begin
            log_data.push_back(m_tdata[31:0]);
            log_strb.push_back(m_tstrb);
            log_src.push_back(m_tuser[23:16]);
            log_len.push_back(m_tuser[15:0]);
            log_last.push_back(m_tlast);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (xfer[i]) begin
                if (xlast[i]) begin
                    beat[i] = 0;
                    pkn[i]++;
                    pk_left[i]--;
                end else begin
                    beat[i]++;
                end
            end else if (!s_tvalid[i] && beat[i] == gap_at[i] && gap_len[i] > 0) begin
                gap_len[i]--;
            end
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pk_left[i] = 0; plen[i] = 1; beat[i] = 0; pkn[i] = 0;
            gap_at[i] = -1; gap_len[i] = 0; usrc[i] = 8'h10 + 8'(i);
        end
        drive_inputs();
        tick();
        tick();
        rst = 1'b0;
        cur_v = 1'b0; cur_r = 1'b1;
        log_data.delete(); log_strb.delete(); log_src.delete();
        log_len.delete(); log_last.delete(); log_cyc.delete();
    endtask

    task automatic run_until(input int n, input int budget);
        for (int k = 0; k < budget && log_data.size() < n; k++)
            tick();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pk_left[i] = 1; plen[i] = 2;
        end
        drive_inputs();
        tick();
        tick();
        n_checks++;
        if (rdy !== 5'b0 || cur_v !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: tready=%b m_tvalid=%b want 00000/0", rdy, cur_v);
        end
        n_checks++;
        if (m_tdata !== '0 || m_tuser !== '0 || m_tstrb !== '0 || m_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fields: tdata/tuser/tstrb/tlast not zero");
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (rdy !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_idle: tready=%b want 00000", rdy);
        end
        tick();
        n_checks++;
        if (rdy !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_first_grant: tready=%b want 00001", rdy);
        end
    endtask

    task automatic test_rotation();
        int ord [6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pk_left[i] = (i == 0) ? 2 : 1;
            plen[i] = 3;
        end
        drive_inputs();
        run_until(18, 80);
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (log_data.size() != 18) begin
            n_fail++;
            $display("FAIL rot_count: beats=%0d want 18", log_data.size());
        end else begin
            for (int k = 0; k < 18; k++) begin
                logic [31:0] exp_d;
                exp_d = {8'h00, 8'(ord[k / 3]), 8'((k / 3 == 5) ? 1 : 0), 8'(k % 3)};
                n_checks++;
                if (log_data[k] !== exp_d || log_last[k] !== (k % 3 == 2) ||
                    log_strb[k] !== ((k % 3 == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF) ||
                    log_src[k] !== 8'h10 + 8'(ord[k / 3]) || log_len[k] !== 16'd3) begin
                    n_fail++;
                    $display("FAIL rot_beat%0d: data=%h last=%b src=%h want %h/%b/%h",
                             k, log_data[k], log_last[k], log_src[k], exp_d,
                             (k % 3 == 2), 8'h10 + 8'(ord[k / 3]));
                end
                if (k > 0) begin
                    n_checks++;
                    if (log_cyc[k] - log_cyc[k - 1] != ((k % 3 == 0) ? 2 : 1)) begin
                        n_fail++;
                        $display("FAIL rot_spacing%0d: gap=%0d want %0d", k,
                                 log_cyc[k] - log_cyc[k - 1], (k % 3 == 0) ? 2 : 1);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pk_left[4] = 1; plen[4] = 1;
        drive_inputs();
        run_until(1, 20);
        pk_left[0] = 1; plen[0] = 1;
        pk_left[1] = 1; plen[1] = 1;
        drive_inputs();
        run_until(3, 30);
        n_checks++;
        if (log_data.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: beats=%0d want 3", log_data.size());
        end else begin
            n_checks++;
            if (log_data[0][23:16] !== 8'd4 || log_data[1][23:16] !== 8'd0 ||
                log_data[2][23:16] !== 8'd1 || log_last[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_order: got %0d,%0d,%0d want 4,0,1",
                         log_data[0][23:16], log_data[1][23:16], log_data[2][23:16]);
            end
        end
    endtask

    task automatic test_backpressure();
        int stalls = 0;
        do_reset();
        pk_left[2] = 1; plen[2] = 4;
        drive_inputs();
        for (int c = 0; c < 40 && log_data.size() < 4; c++) begin
            m_tready = (c % 2 == 0);
            tick();
            if (prv_v && !prv_r) begin
                stalls++;
                n_checks++;
                if (cur_v !== 1'b1 || cur_d !== prv_d || cur_u !== prv_u || cur_l !== prv_l) begin
                    n_fail++;
                    $display("FAIL bp_stable: data=%h last=%b valid=%b want %h/%b/1",
                             cur_d, cur_l, cur_v, prv_d, prv_l);
                end
            end
        end
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (stalls == 0 || log_data.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: beats=%0d stalls=%0d want 4/>0", log_data.size(), stalls);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (log_data[k] !== {16'h0002, 16'(k)} || log_last[k] !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: data=%h last=%b want %h/%b",
                             k, log_data[k], log_last[k], {16'h0002, 16'(k)}, (k == 3));
                end
            end
        end
    endtask

    task automatic test_gap_block();
        logic done1 = 1'b0;
        do_reset();
        pk_left[1] = 1; plen[1] = 4; gap_at[1] = 2; gap_len[1] = 3;
        pk_left[3] = 1; plen[3] = 2;
        drive_inputs();
        for (int c = 0; c < 40 && log_data.size() < 6; c++) begin
            tick();
            if (!done1) begin
                n_checks++;
                if (rdy[3] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_block: tready_3=%b want 0 at cycle %0d", rdy[3], c);
                end
            end
            if (xlast[1]) done1 = 1'b1;
        end
        n_checks++;
        if (log_data.size() != 6) begin
            n_fail++;
            $display("FAIL gap_count: beats=%0d want 6", log_data.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (log_data[k][23:16] !== ((k < 4) ? 8'd1 : 8'd3) ||
                    log_data[k][7:0] !== ((k < 4) ? 8'(k) : 8'(k - 4))) begin
                    n_fail++;
                    $display("FAIL gap_beat%0d: data=%h", k, log_data[k]);
                end
            end
        end
    endtask

    task automatic test_src_stamp();
        logic [7:0] exp0;
`ifdef NF10_INPUT_ARBITER_SRC_STAMP_EN
        exp0 = 8'h40;
`else
        exp0 = 8'hFF;
`endif
        do_reset();
        pk_left[3] = 1; plen[3] = 2; usrc[3] = 8'hFF;
        drive_inputs();
        run_until(2, 20);
        n_checks++;
        if (log_data.size() != 2) begin
            n_fail++;
            $display("FAIL stamp_count: beats=%0d want 2", log_data.size());
        end else begin
            n_checks++;
            if (log_src[0] !== exp0 || log_src[1] !== 8'hFF || log_len[0] !== 16'd2) begin
                n_fail++;
                $display("FAIL stamp_src: got %h,%h len=%0d want %h,ff len=2",
                         log_src[0], log_src[1], log_len[0], exp0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        cur_v = 1'b0; cur_r = 1'b1; cur_l = 1'b0; cur_d = '0; cur_u = '0;
        prv_v = 1'b0; prv_r = 1'b1; prv_l = 1'b0; prv_d = '0; prv_u = '0;
        test_reset();
        test_rotation();
        test_wrap();
        test_backpressure();
        test_gap_block();
        test_src_stamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
